pipe_stage_elastic: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers: a STAGES-deep, WIDTH-bit elastic pipeline register with per-stage valid bits.
- Adds valid/ready flow control with bubble collapsing, synchronous flush, an occupancy count and a saturating stall counter.
- Sits between any two processor pipeline stages (e.g. MEM→WB). The payload is the concatenated bundle of stage signals: ALU result, memory data, control bits.

---
 rtl/pipe_stage_elastic_if.sv | 22 ++
 rtl/pipe_stage_elastic.sv | 99 +++++++++
 tb/tb_pipe_stage_elastic.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle for the elastic pipeline register: upstream
// (in_*) and downstream (out_*) sides grouped so the stage plugs in as one port.
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // master drives the stage (producer + consumer side), slave is the stage itself
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// STAGES-deep elastic pipeline register with bubble collapsing, synchronous
// flush, occupancy reporting and a saturating output-stall counter.
module pipe_stage_elastic #(
    parameter int WIDTH      = 32,
    parameter int STAGES     = 1,
    parameter bit RESET_DATA = 1'b1,
    parameter int CNT_W      = 16,
    localparam int OCC_W     = $clog2(STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   stall_clr,
    pipe_stage_elastic_if.slave    bus,
    output logic [OCC_W-1:0]       occupancy,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic [STAGES-1:0] valid_q, valid_d, adv;
    logic [STAGES:0]   vchain;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  dchain [STAGES+1];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // A slot may advance if it is empty or the slot ahead of it advances.
    always_comb begin
        logic a;
        // NOTE: blocking assignments here build the ripple chain combinationally;
        // every variable gets a value on every pass so no latch is inferred.
        a   = bus.out_ready;
        adv = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            a      = !valid_q[i] | a;
            adv[i] = a;
        end
    end

    assign vchain = {valid_q, bus.in_valid};

    always_comb begin
        dchain[0] = bus.in_data;
        for (int i = 0; i < STAGES; i++) dchain[i+1] = data_q[i];
    end

    // Flush wins over every advance; stalled slots hold.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++)
            valid_d[i] = flush ? 1'b0 : (adv[i] ? vchain[i] : valid_q[i]);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr)
            stall_cnt_d = '0;
        else if (valid_q[STAGES-1] && !bus.out_ready && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: the payload array is only reset when asked to; leaving it unreset
    // lets it map onto plain enable flops since valid bits already mask it.
    if (RESET_DATA) begin : g_data_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
            end else begin
                for (int i = 0; i < STAGES; i++)
                    if (adv[i]) data_q[i] <= dchain[i];
            end
        end
    end else begin : g_data_norst
        always_ff @(posedge clk) begin
            for (int i = 0; i < STAGES; i++)
                if (adv[i]) data_q[i] <= dchain[i];
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCC_W'(valid_q[i]);
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Drives a 3-stage and a 2-stage instance with identical stimulus and compares
// both against an entry-list reference model of the elastic pipe.
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic stall_clr = 1'b0;
    logic [1:0] occ3, occ2;
    logic [3:0] sc3, sc2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic_if #(.WIDTH(32)) if3 ();
    pipe_stage_elastic_if #(.WIDTH(32)) if2 ();

    pipe_stage_elastic #(.WIDTH(32), .STAGES(3), .RESET_DATA(1'b1), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_clr(stall_clr),
        .bus(if3), .occupancy(occ3), .stall_cnt(sc3)
    );
    pipe_stage_elastic #(.WIDTH(32), .STAGES(2), .RESET_DATA(1'b1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_clr(stall_clr),
        .bus(if2), .occupancy(occ2), .stall_cnt(sc2)
    );

    // Reference model: per instance, an ordered list of in-flight entries
    // (oldest first) with the slot position each currently occupies.
    int          m_s [2] = '{3, 2};
    logic [31:0] m_data [2][4];
    int          m_pos [2][4];
    int          m_n [2];
    int          m_cnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit head_at_out(int k);
        return m_n[k] > 0 && m_pos[k][0] == m_s[k] - 1;
    endfunction

    // Slot 0 is free after the edge iff the youngest entry (if any) moves off it.
    function automatic bit model_in_ready(int k, bit ordy);
        int lim, j0, np;
        lim = m_s[k];
        j0  = (head_at_out(k) && ordy) ? 1 : 0;
        for (int j = j0; j < m_n[k]; j++) begin
            np  = (m_pos[k][j] + 1 < lim) ? m_pos[k][j] + 1 : m_pos[k][j];
            lim = np;
        end
        return lim > 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k]   = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(int k, bit iv, logic [31:0] id, bit ordy, bit fl, bit clr);
        bit ir;
        int lim;
        ir = model_in_ready(k, ordy);
        if (clr) m_cnt[k] = 0;
        else if (head_at_out(k) && !ordy && m_cnt[k] < 15) m_cnt[k]++;
        if (fl) begin
            m_n[k] = 0;
            return;
        end
        if (head_at_out(k) && ordy) begin
            for (int j = 1; j < m_n[k]; j++) begin
                m_data[k][j-1] = m_data[k][j];
                m_pos[k][j-1]  = m_pos[k][j];
            end
            m_n[k]--;
        end
        lim = m_s[k];
        for (int j = 0; j < m_n[k]; j++) begin
            if (m_pos[k][j] + 1 < lim) m_pos[k][j]++;
            lim = m_pos[k][j];
        end
        if (iv && ir) begin
            m_data[k][m_n[k]] = id;
            m_pos[k][m_n[k]]  = 0;
            m_n[k]++;
        end
    endtask

    task automatic check_dut(int k, logic ov, logic [31:0] od, logic ir,
                             logic [1:0] occ, logic [3:0] sc, bit ordy);
        string p;
        p = (k == 0) ? "s3" : "s2";
        check({p, ".out_valid"}, 32'(ov), 32'(head_at_out(k)));
        if (head_at_out(k)) check({p, ".out_data"}, od, m_data[k][0]);
        check({p, ".in_ready"}, 32'(ir), 32'(model_in_ready(k, ordy)));
        check({p, ".occupancy"}, 32'(occ), 32'(m_n[k]));
        check({p, ".stall_cnt"}, 32'(sc), 32'(m_cnt[k]));
    endtask

    // One clock: apply inputs, compare at the falling edge, advance the model
    // on the rising edge, return 1 time unit after it.
    task automatic cycle(bit iv, logic [31:0] id, bit ordy, bit fl, bit clr);
        if3.in_valid = iv;  if3.in_data = id;  if3.out_ready = ordy;
        if2.in_valid = iv;  if2.in_data = id;  if2.out_ready = ordy;
        flush = fl;
        stall_clr = clr;
        @(negedge clk);
        check_dut(0, if3.out_valid, if3.out_data, if3.in_ready, occ3, sc3, ordy);
        check_dut(1, if2.out_valid, if2.out_data, if2.in_ready, occ2, sc2, ordy);
        @(posedge clk);
        model_step(0, iv, id, ordy, fl, clr);
        model_step(1, iv, id, ordy, fl, clr);
        #1;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, ".s3.out_valid"}, 32'(if3.out_valid), 32'd0);
        check({tag, ".s3.in_ready"}, 32'(if3.in_ready), 32'd1);
        check({tag, ".s3.occupancy"}, 32'(occ3), 32'd0);
        check({tag, ".s3.stall_cnt"}, 32'(sc3), 32'd0);
        check({tag, ".s3.out_data"}, if3.out_data, 32'd0);
        check({tag, ".s2.out_valid"}, 32'(if2.out_valid), 32'd0);
        check({tag, ".s2.in_ready"}, 32'(if2.in_ready), 32'd1);
        check({tag, ".s2.out_data"}, if2.out_data, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int peak;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;
        model_reset();

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming 1..4 with out_ready held high
        peak = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(i <= 4, 32'(i), 1'b1, 1'b0, 1'b0);
            if (int'(occ3) > peak) peak = int'(occ3);
        end
        check("stream.peak_occupancy", 32'(peak), 32'd3);

        // Backpressure with a bubble between 0xA and 0xB
        cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("bp.occupancy", 32'(occ3), 32'd2);
        check("bp.out_data", if3.out_data, 32'hA);
        check("bp.in_ready", 32'(if3.in_ready), 32'd1);
        drain();

        // Full shift on the 2-stage instance
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        check("shift.full_occ", 32'(occ2), 32'd2);
        cycle(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
        check("shift.occ", 32'(occ2), 32'd2);
        check("shift.out_data", if2.out_data, 32'h11);
        drain();

        // Flush a full 3-stage pipe while 0x55 is offered
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0, 1'b0);
        check("flush.pre_occ", 32'(occ3), 32'd3);
        cycle(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
        check("flush.occ", 32'(occ3), 32'd0);
        check("flush.out_valid", 32'(if3.out_valid), 32'd0);
        drain();

        // Stall counter saturation and clear
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("sat.s3.stall_cnt", 32'(sc3), 32'd15);
        check("sat.s2.stall_cnt", 32'(sc2), 32'd15);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("clr.s3.stall_cnt", 32'(sc3), 32'd0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);

        // Asynchronous reset between edges, mid-stream
        repeat (3) cycle(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
        check("areset.pre_out_valid", 32'(if3.out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset.s3.out_valid", 32'(if3.out_valid), 32'd0);
        check("areset.s2.out_valid", 32'(if2.out_valid), 32'd0);
        check("areset.s3.occupancy", 32'(occ3), 32'd0);
        model_reset();
        if3.in_valid = 1'b0; if2.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("areset");
        rst_n = 1'b1;
        repeat (4) cycle(1'b1, $urandom(), 1'b1, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
